// File: rtl/cart_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// cart_load_ctrl_if
//   Signal bundle between the cartridge load controller, the HPS ioctl
//   download channel, the cartridge ROM dpram port A and the console core.
//
//   master : the load controller (consumes ioctl/ROM read data, drives ROM
//            port A and the core configuration/reset outputs)
//   slave  : the surrounding system (hps_io, dpram, A2601 core)
//
//   ioctl_download  download active
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      25-bit byte address
//   ioctl_dout      byte data
//   ext             normalized 3-char file extension (e.g. ".F8")
//   ext_s           file name ends in "S"
//   sc_mode         0=Auto, 1=Disable, 2=Enable
//   mem_q           ROM port-A read data, 1-cycle latency
//   mem_addr        ROM port-A address
//   mem_din         ROM port-A write data
//   mem_we          ROM port-A write enable
//   rom_size        loaded byte count
//   force_bs        bankswitch scheme code
//   sc              SuperChip RAM enable
//   core_reset      hold core in reset
//   busy            controller not idle
//   overflow        a byte at or above the ROM size was discarded
// -----------------------------------------------------------------------------
interface cart_load_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [23:0]       ext;
    logic              ext_s;
    logic [1:0]        sc_mode;
    logic [7:0]        mem_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic [16:0]       rom_size;
    logic [3:0]        force_bs;
    logic              sc;
    logic              core_reset;
    logic              busy;
    logic              overflow;

    modport master (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ext, ext_s, sc_mode, mem_q,
        output mem_addr, mem_din, mem_we,
        output rom_size, force_bs, sc, core_reset, busy, overflow
    );

    modport slave (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output ext, ext_s, sc_mode, mem_q,
        input  mem_addr, mem_din, mem_we,
        input  rom_size, force_bs, sc, core_reset, busy, overflow
    );
endinterface

// File: rtl/cart_load_ctrl.sv
// -----------------------------------------------------------------------------
// cart_load_ctrl
//   Sequences a cartridge load into the cartridge ROM dpram: writes the HPS
//   download bytes into ROM port A, replicates short images up to
//   MIRROR_SIZE, picks the bankswitch scheme and SuperChip enable, and holds
//   the console core in reset until a settle delay has elapsed.
//
//   clk_sys   system clock
//   reset_n   synchronous active-low reset
//   bus       cart_load_ctrl_if.master (ioctl download, ROM port A,
//             core configuration and status; see the interface header)
// -----------------------------------------------------------------------------
module cart_load_ctrl #(
    parameter int ADDR_W         = 15,
    parameter int MIRROR_SIZE    = 4096,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    cart_load_ctrl_if.master    bus
);

    localparam int CNT_W = $clog2(RELEASE_CYCLES + 1) > 0 ? $clog2(RELEASE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MIRROR_RD,
        S_MIRROR_WR,
        S_DETECT,
        S_SETTLE
    } state_t;

    state_t            r_state,      w_state_nx;
    logic              r_dl;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
    logic [7:0]        r_mem_din,    w_mem_din_nx;
    logic              r_mem_we,     w_mem_we_nx;
    logic [16:0]       r_rom_size,   w_rom_size_nx;
    logic [3:0]        r_force_bs,   w_force_bs_nx;
    logic              r_sc,         w_sc_nx;
    logic              r_core_reset, w_core_reset_nx;
    logic              r_overflow,   w_overflow_nx;
    logic [ADDR_W-1:0] r_src,        w_src_nx;
    logic [ADDR_W-1:0] r_dst,        w_dst_nx;
    logic [CNT_W-1:0]  r_cnt,        w_cnt_nx;

    logic              w_dl_rise;
    logic              w_dl_fall;
    logic              w_in_rom;
    logic              w_load_wr;
    logic [16:0]       w_addr_p1;
    logic [16:0]       w_size_upd;

    // Download edges are taken against the registered copy of the level.
    assign w_dl_rise = bus.ioctl_download & ~r_dl;
    assign w_dl_fall = ~bus.ioctl_download & r_dl;

    // Any address bit at or above ADDR_W set means the byte lies outside the
    // ROM; those bytes must never alias back into it.
    assign w_in_rom  = (bus.ioctl_addr[24:ADDR_W] == '0);
    assign w_load_wr = (r_state == S_LOAD) && bus.ioctl_wr && w_in_rom;
    assign w_addr_p1 = 17'(bus.ioctl_addr[ADDR_W-1:0]) + 17'd1;

    // rom_size including a byte strobed this cycle, so a byte coinciding with
    // the falling edge still counts towards the mirror decision.
    assign w_size_upd = (w_load_wr && (w_addr_p1 > r_rom_size)) ? w_addr_p1 : r_rom_size;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_dl         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_mem_we     <= 1'b0;
            r_rom_size   <= '0;
            r_force_bs   <= '0;
            r_sc         <= 1'b0;
            r_core_reset <= 1'b1;
            r_overflow   <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_dl         <= bus.ioctl_download;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_din    <= w_mem_din_nx;
            r_mem_we     <= w_mem_we_nx;
            r_rom_size   <= w_rom_size_nx;
            r_force_bs   <= w_force_bs_nx;
            r_sc         <= w_sc_nx;
            r_core_reset <= w_core_reset_nx;
            r_overflow   <= w_overflow_nx;
            r_src        <= w_src_nx;
            r_dst        <= w_dst_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_din_nx    = r_mem_din;
        w_mem_we_nx     = 1'b0;
        w_rom_size_nx   = r_rom_size;
        w_force_bs_nx   = r_force_bs;
        w_sc_nx         = r_sc;
        w_core_reset_nx = r_core_reset;
        w_overflow_nx   = r_overflow;
        w_src_nx        = r_src;
        w_dst_nx        = r_dst;
        w_cnt_nx        = r_cnt;

        if (w_dl_rise) begin
            // A new download always wins, aborting mirror/detect/settle.
            w_state_nx      = S_LOAD;
            w_rom_size_nx   = '0;
            w_overflow_nx   = 1'b0;
            w_core_reset_nx = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_core_reset_nx = 1'b0;
                end

                S_LOAD: begin
                    if (bus.ioctl_wr) begin
                        if (w_in_rom) begin
                            w_mem_we_nx   = 1'b1;
                            w_mem_addr_nx = bus.ioctl_addr[ADDR_W-1:0];
                            w_mem_din_nx  = bus.ioctl_dout;
                        end else begin
                            w_overflow_nx = 1'b1;
                        end
                    end
                    w_rom_size_nx = w_size_upd;
                    if (w_dl_fall) begin
                        if ((w_size_upd != '0) && (w_size_upd < 17'(MIRROR_SIZE))) begin
                            w_state_nx = S_MIRROR_RD;
                            w_src_nx   = '0;
                            w_dst_nx   = w_size_upd[ADDR_W-1:0];
                        end else begin
                            w_state_nx = S_DETECT;
                        end
                    end
                end

                S_MIRROR_RD: begin
                    // A final download byte still in the write register owns
                    // port A this cycle; issue the read once it has drained.
                    if (!r_mem_we) begin
                        w_state_nx = S_MIRROR_WR;
                    end
                end

                S_MIRROR_WR: begin
                    w_dst_nx = r_dst + ADDR_W'(1);
                    if (17'(r_src) == (r_rom_size - 17'd1)) begin
                        w_src_nx = '0;
                    end else begin
                        w_src_nx = r_src + ADDR_W'(1);
                    end
                    if (r_dst == ADDR_W'(MIRROR_SIZE - 1)) begin
                        w_state_nx = S_DETECT;
                    end else begin
                        w_state_nx = S_MIRROR_RD;
                    end
                end

                S_DETECT: begin
                    case (bus.ext)
                        ".F8":   w_force_bs_nx = 4'd1;
                        ".F6":   w_force_bs_nx = 4'd2;
                        ".FE":   w_force_bs_nx = 4'd3;
                        ".E0":   w_force_bs_nx = 4'd4;
                        ".3F":   w_force_bs_nx = 4'd5;
                        ".F4":   w_force_bs_nx = 4'd6;
                        ".P2":   w_force_bs_nx = 4'd7;
                        ".FA":   w_force_bs_nx = 4'd8;
                        ".CV":   w_force_bs_nx = 4'd9;
                        default: begin
                            case (r_rom_size)
                                17'd8192:  w_force_bs_nx = 4'd1;
                                17'd16384: w_force_bs_nx = 4'd2;
                                17'd32768: w_force_bs_nx = 4'd6;
                                17'd12288: w_force_bs_nx = 4'd8;
                                default:   w_force_bs_nx = 4'd0;
                            endcase
                        end
                    endcase
                    w_sc_nx    = (bus.sc_mode == 2'd0) ? bus.ext_s : bus.sc_mode[1];
                    w_cnt_nx   = CNT_W'(RELEASE_CYCLES);
                    w_state_nx = S_SETTLE;
                end

                S_SETTLE: begin
                    // Release when the count reaches zero on this edge, so the
                    // core stays in reset for exactly RELEASE_CYCLES cycles.
                    if (r_cnt <= CNT_W'(1)) begin
                        w_cnt_nx        = '0;
                        w_core_reset_nx = 1'b0;
                        w_state_nx      = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Port A: the load pipeline register drives it, except while mirroring,
    // where the read address and the write of the returned byte come straight
    // from the state so mem_q is consumed in the cycle it is valid.
    always_comb begin
        bus.mem_addr = r_mem_addr;
        bus.mem_din  = r_mem_din;
        bus.mem_we   = r_mem_we;
        if ((r_state == S_MIRROR_RD) && !r_mem_we) begin
            bus.mem_addr = r_src;
            bus.mem_we   = 1'b0;
        end else if (r_state == S_MIRROR_WR) begin
            bus.mem_addr = r_dst;
            bus.mem_din  = bus.mem_q;
            bus.mem_we   = 1'b1;
        end
    end

    assign bus.rom_size   = r_rom_size;
    assign bus.force_bs   = r_force_bs;
    assign bus.sc         = r_sc;
    assign bus.core_reset = r_core_reset;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
